// File: rtl/apb_cmd_master.sv
// APB initiator: converts a valid/ready command stream into APB setup/access
// transfers and returns one response per command (read data or timeout error).
module apb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    output logic [1:0]        o_dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // Counter value at which one more PREADY-low ACCESS cycle means abort.
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic w_accept;
    logic w_timeout;

    assign w_accept  = cmd_valid && r_cmd_ready;
    assign w_timeout = (TIMEOUT != 0) && !PREADY && (r_cnt == LP_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pwrite    <= cmd_write;
                        r_paddr     <= cmd_addr;
                        r_pwdata    <= cmd_wdata;
                        r_psel      <= 1'b1;
                        r_cnt       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_timeout) begin
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_psel      <= 1'b0;
                            r_penable   <= 1'b0;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    // Response fields stay frozen until the consumer takes them.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign busy        = r_busy;
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed plus randomized bench for apb_cmd_master against a command-level
// model (latency/response rules) and a reactive APB slave with its own memory.
module tb_apb_cmd_master;

    localparam int TMO = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [1:0]  o_dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];

    apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .CNT_W(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .o_dbg_state(o_dbg_state)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input int hold, input logic pend, input int rst_at);
        int c, psel_n, pen_n, acc_seen, rsp_cyc, exp_pen, exp_lat;
        logic done, exp_err;
        logic [31:0] exp_rd;
        // Command-level expectations: wait count decides completion vs abort.
        exp_err = (TMO != 0) && (waits >= TMO);
        exp_rd  = 32'h0;
        if (!wr && !exp_err && ref_mem.exists(addr)) exp_rd = ref_mem[addr];
        exp_lat = exp_err ? 2 + TMO : 3 + waits;
        exp_pen = exp_err ? TMO : waits + 1;
        if (wr && !exp_err && rst_at < 0) ref_mem[addr] = wdata;

        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        @(posedge PCLK); @(negedge PCLK);
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;

        c = 1; psel_n = 0; pen_n = 0; acc_seen = 0; rsp_cyc = 0; done = 1'b0;
        while (!done && c < 60) begin
            if (rsp_valid) begin
                done = 1'b1; rsp_cyc = c; rsp_ready = 1'b0; PREADY = 1'b0;
            end else begin
                if (PSEL) begin
                    psel_n++;
                    chk("paddr_stable", PADDR, addr);
                    chk("pwrite_stable", PWRITE, wr);
                    if (wr) chk("pwdata_stable", PWDATA, wdata);
                end
                if (PENABLE) pen_n++;
                if (PSEL && PENABLE) begin
                    if (acc_seen == rst_at) begin
                        PRESETn = 1'b0; PREADY = 1'b0; rsp_ready = 1'b0;
                        #1;
                        chk("rst_psel", PSEL, 0);
                        chk("rst_penable", PENABLE, 0);
                        chk("rst_rsp_valid", rsp_valid, 0);
                        chk("rst_busy", busy, 0);
                        @(negedge PCLK);
                        PRESETn = 1'b1;
                        for (int i = 0; i < 3; i++) begin
                            @(posedge PCLK); @(negedge PCLK);
                            chk("post_rst_no_rsp", rsp_valid, 0);
                            chk("post_rst_cmd_ready", cmd_ready, 1);
                        end
                        return;
                    end
                    acc_seen++;
                    PREADY = (acc_seen > waits);
                    PRDATA = $urandom;
                    if (PREADY) begin
                        if (PWRITE) slave_mem[PADDR] = PWDATA;
                        else if (slave_mem.exists(PADDR)) PRDATA = slave_mem[PADDR];
                        else PRDATA = 32'h0;
                    end
                end else begin
                    PREADY = 1'($urandom_range(0, 1));
                    PRDATA = $urandom;
                end
                rsp_ready = 1'($urandom_range(0, 1));
                @(posedge PCLK); @(negedge PCLK);
                c++;
            end
        end
        if (!done) begin
            chk("rsp_within_budget", 0, 1);
            return;
        end
        chk("rsp_latency", rsp_cyc, exp_lat);
        chk("psel_cycles", psel_n, exp_pen + 1);
        chk("penable_cycles", pen_n, exp_pen);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_psel_low", PSEL, 0);
        chk("rsp_cmd_ready", cmd_ready, 0);
        chk("rsp_busy", busy, 1);
        for (int h = 0; h < hold; h++) begin
            if (pend) cmd_valid = 1'b1;
            PREADY = 1'($urandom_range(0, 1));
            @(posedge PCLK); @(negedge PCLK);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", rsp_err, exp_err);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_psel", PSEL, 0);
        end
        rsp_ready = 1'b1;
        @(posedge PCLK); @(negedge PCLK);
        rsp_ready = 1'b0; PREADY = 1'b0;
        chk("done_valid_low", rsp_valid, 0);
        chk("done_cmd_ready", cmd_ready, 1);
        chk("done_busy", busy, 0);
        chk("done_psel", PSEL, 0);
    endtask

    initial begin
        logic        r_wr;
        logic [31:0] r_addr;
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset_psel", PSEL, 0);
        chk("reset_penable", PENABLE, 0);
        chk("reset_pwrite", PWRITE, 0);
        chk("reset_paddr", PADDR, 0);
        chk("reset_pwdata", PWDATA, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_state_idle", o_dbg_state, 0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // GPIO output-enable register: write all ones, read back.
        run_cmd(1'b1, 32'h08, 32'hFFFF_FFFF, 0, 0, 1'b0, -1);
        run_cmd(1'b0, 32'h08, 32'h0, 0, 0, 1'b0, -1);
        ref_mem[32'h10] = 32'hAABB_CCDD;
        slave_mem[32'h10] = 32'hAABB_CCDD;
        run_cmd(1'b0, 32'h10, 32'h0, 3, 0, 1'b0, -1);
        run_cmd(1'b0, 32'h10, 32'h0, 50, 0, 1'b0, -1);
        run_cmd(1'b1, 32'h20, 32'h1234_5678, 0, 0, 1'b0, -1);
        run_cmd(1'b0, 32'h20, 32'h0, TMO - 1, 0, 1'b0, -1);
        run_cmd(1'b1, 32'h24, 32'h0BAD_F00D, TMO, 0, 1'b0, -1);
        run_cmd(1'b0, 32'h20, 32'h0, 0, 5, 1'b1, -1);
        run_cmd(1'b0, 32'h24, 32'h0, 1, 0, 1'b0, -1);
        run_cmd(1'b0, 32'h10, 32'h0, 50, 0, 1'b0, 1);
        run_cmd(1'b1, 32'h30, 32'hCAFE_0001, 0, 0, 1'b0, -1);
        run_cmd(1'b0, 32'h30, 32'h0, 2, 1, 1'b0, -1);

        for (int k = 0; k < 40; k++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = 32'(4 * $urandom_range(0, 7));
            run_cmd(r_wr, r_addr, $urandom, $urandom_range(0, TMO + 1),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
        end
        cmd_valid = 1'b0;
        repeat (2) @(posedge PCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
